net_tx_arbiter: RTL and testbench

- Frame-level round-robin arbiter. Shares the single net-side byte stream (toward MAC/PHY tx) between NUM_SRC AXI-Stream frame sources, e.g. the UDP transmit path (trans_tnet_*) and the ARP transmit path.
- Grant is locked for a whole frame, from first beat to tlast. A programmable idle gap is inserted between frames.
- Sits between the transport/ARP layers and the MAC tx interface.

---
 rtl/net_arb_pkg.sv | 39 +++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/net_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_net_tx_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_arb_pkg.sv
// Shared types and helpers for the net transmit arbiter.
// - arb_state_e : arbiter FSM states (StDrain only reachable with NET_ARB_WATCHDOG_EN)
// - rr_pick_t   : result of a round-robin search (found flag + index)
// - rr_pick()   : first set request bit at or above ptr, wrapping, among num sources
package net_arb_pkg;

  // Upper bound on sources; request vectors are padded to this width for rr_pick().
  localparam int unsigned MaxSrc  = 8;
  localparam int unsigned MaxIdxW = 3;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StGap,
    StDrain
  } arb_state_e;

  typedef struct packed {
    logic               found;
    logic [MaxIdxW-1:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [MaxSrc-1:0]  req,
                                       input logic [MaxIdxW-1:0] ptr,
                                       input int unsigned        num);
    rr_pick_t           res;
    logic [MaxIdxW-1:0] cand;
    res = '0;
    for (int unsigned k = 0; k < MaxSrc; k++) begin
      cand = MaxIdxW'((32'(ptr) + k) % num);
      if (k < num && !res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker with a registered priority pointer.
// - clk_i, rst_ni : clock, asynchronous active-low reset
// - req_i         : request vector
// - advance_i     : pulse to move the pointer past last_idx_i
// - last_idx_i    : index just served
// - pick_valid_o  : some request is set
// - pick_idx_o    : first request at or above the pointer, wrapping
module rr_arbiter
  import net_arb_pkg::*;
#(
  parameter int unsigned NumSrc = 2,
  localparam int unsigned IdxW  = $clog2(NumSrc)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumSrc-1:0] req_i,
  input  logic              advance_i,
  input  logic [IdxW-1:0]   last_idx_i,
  output logic              pick_valid_o,
  output logic [IdxW-1:0]   pick_idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  rr_pick_t        pick;

  always_comb begin
    pick         = rr_pick(MaxSrc'(req_i), MaxIdxW'(ptr_q), NumSrc);
    pick_valid_o = pick.found;
    pick_idx_o   = IdxW'(pick.idx);
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (last_idx_i == IdxW'(NumSrc - 1)) ? '0 : last_idx_i + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/net_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one net-side byte stream among NUM_SRC
// AXI-Stream frame sources. Grant is held from the first beat to tlast, followed
// by IFG_CYCLES idle cycles before the next arbitration cycle.
// Optional feature macro: NET_ARB_WATCHDOG_EN -- caps frames at MAX_FRAME_BEATS beats,
// forcing tlast, pulsing frame_abort_out and draining the rest of the source frame.
// Ports:
// - logic_clk, logic_rstn : clock, asynchronous active-low reset
// - src_t*                : per-source streams (source i data at [i*W +: W])
// - net_t*                : muxed downstream stream
// - grant_id_out          : current or last granted source
// - grant_active_out      : high while a frame is being transferred
// - frame_abort_out       : one-cycle pulse on the beat that hits the length cap
module net_tx_arbiter
  import net_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC         = 2,
  parameter int unsigned TDATA_WIDTH     = 8,
  parameter int unsigned IFG_CYCLES      = 12,
  parameter int unsigned MAX_FRAME_BEATS = 1514
) (
  input  logic                           logic_clk,
  input  logic                           logic_rstn,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0] src_tdata_in,
  input  logic [NUM_SRC-1:0]             src_tvalid_in,
  output logic [NUM_SRC-1:0]             src_tready_out,
  input  logic [NUM_SRC-1:0]             src_tlast_in,
  output logic [TDATA_WIDTH-1:0]         net_tdata_out,
  output logic                           net_tvalid_out,
  input  logic                           net_tready_in,
  output logic                           net_tlast_out,
  output logic [$clog2(NUM_SRC)-1:0]     grant_id_out,
  output logic                           grant_active_out,
  output logic                           frame_abort_out
);

  localparam int unsigned IdxW = $clog2(NUM_SRC);
  localparam int unsigned GapW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  if (NUM_SRC < 2 || NUM_SRC > MaxSrc || MAX_FRAME_BEATS < 1 || MAX_FRAME_BEATS > 65535)
  begin : g_bad_param
    $error("net_tx_arbiter: unsupported parameter value");
  end

  arb_state_e       state_q, state_d;
  logic [IdxW-1:0]  gnt_q, gnt_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             pick_valid;
  logic [IdxW-1:0]  pick_idx;
  logic             rr_advance;
  logic             frame_done;

`ifdef NET_ARB_WATCHDOG_EN
  logic [15:0]      beat_q, beat_d;
  logic             at_limit;
`endif

  logic [TDATA_WIDTH-1:0] src_data [NUM_SRC];
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_data[i] = src_tdata_in[i*TDATA_WIDTH +: TDATA_WIDTH];
  end

  rr_arbiter #(
    .NumSrc (NUM_SRC)
  ) u_rr_arbiter (
    .clk_i        (logic_clk),
    .rst_ni       (logic_rstn),
    .req_i        (src_tvalid_in),
    .advance_i    (rr_advance),
    .last_idx_i   (gnt_q),
    .pick_valid_o (pick_valid),
    .pick_idx_o   (pick_idx)
  );

  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    gap_d           = gap_q;
    rr_advance      = 1'b0;
    frame_done      = 1'b0;
    src_tready_out  = '0;
    net_tvalid_out  = 1'b0;
    net_tlast_out   = 1'b0;
    net_tdata_out   = '0;
    frame_abort_out = 1'b0;
`ifdef NET_ARB_WATCHDOG_EN
    beat_d   = beat_q;
    at_limit = (beat_q == 16'(MAX_FRAME_BEATS - 1));
`endif

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d   = pick_idx;
          state_d = StXfer;
`ifdef NET_ARB_WATCHDOG_EN
          beat_d  = '0;
`endif
        end
      end

      StXfer: begin
        net_tvalid_out        = src_tvalid_in[gnt_q];
        net_tdata_out         = src_data[gnt_q];
        net_tlast_out         = src_tlast_in[gnt_q];
        src_tready_out[gnt_q] = net_tready_in;
`ifdef NET_ARB_WATCHDOG_EN
        // Present a forced tlast on the capped beat so the MAC sees a closed frame.
        if (at_limit) net_tlast_out = 1'b1;
`endif
        if (src_tvalid_in[gnt_q] && net_tready_in) begin
          if (src_tlast_in[gnt_q]) begin
            frame_done = 1'b1;
`ifdef NET_ARB_WATCHDOG_EN
          end else if (at_limit) begin
            frame_abort_out = 1'b1;
            state_d         = StDrain;
          end else begin
            beat_d = beat_q + 16'd1;
`endif
          end
        end
      end

      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

`ifdef NET_ARB_WATCHDOG_EN
      // Swallow the rest of the oversized frame; nothing reaches the net side.
      StDrain: begin
        src_tready_out[gnt_q] = 1'b1;
        if (src_tvalid_in[gnt_q] && src_tlast_in[gnt_q]) frame_done = 1'b1;
      end
`endif

      default: state_d = StIdle;
    endcase

    if (frame_done) begin
      rr_advance = 1'b1;
      if (IFG_CYCLES > 0) begin
        state_d = StGap;
        gap_d   = GapW'(IFG_CYCLES - 1);
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge logic_clk or negedge logic_rstn) begin
    if (!logic_rstn) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      gap_q   <= '0;
`ifdef NET_ARB_WATCHDOG_EN
      beat_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gap_q   <= gap_d;
`ifdef NET_ARB_WATCHDOG_EN
      beat_q  <= beat_d;
`endif
    end
  end

  assign grant_id_out     = gnt_q;
  assign grant_active_out = (state_q == StXfer);

endmodule

// File: tb/tb_net_tx_arbiter.sv
module tb_net_tx_arbiter;

  localparam int N   = 2;
  localparam int W   = 8;
  localparam int IFG = 12;
`ifdef NET_ARB_WATCHDOG_EN
  localparam int MaxBeats = 16;
  localparam bit Wd       = 1'b1;
  localparam int ALen     = 16;
`else
  localparam int MaxBeats = 1514;
  localparam bit Wd       = 1'b0;
  localparam int ALen     = 60;
`endif

  localparam int PIdle = 0, PXfer = 1, PGap = 2, PDrain = 3;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N*W-1:0] src_tdata;
  logic [N-1:0]   src_tvalid, src_tready, src_tlast;
  logic [W-1:0]   net_tdata;
  logic           net_tvalid, net_tready, net_tlast;
  logic [0:0]     grant_id;
  logic           grant_active, frame_abort;

  always #5 clk = ~clk;

  net_tx_arbiter #(
    .NUM_SRC         (N),
    .TDATA_WIDTH     (W),
    .IFG_CYCLES      (IFG),
    .MAX_FRAME_BEATS (MaxBeats)
  ) dut (
    .logic_clk        (clk),
    .logic_rstn       (rstn),
    .src_tdata_in     (src_tdata),
    .src_tvalid_in    (src_tvalid),
    .src_tready_out   (src_tready),
    .src_tlast_in     (src_tlast),
    .net_tdata_out    (net_tdata),
    .net_tvalid_out   (net_tvalid),
    .net_tready_in    (net_tready),
    .net_tlast_out    (net_tlast),
    .grant_id_out     (grant_id),
    .grant_active_out (grant_active),
    .frame_abort_out  (frame_abort)
  );

  int checks = 0, fails = 0, cyc = 0;

  // Sources: queued frames (bytes + lengths) and position inside the head frame.
  logic [7:0] sbytes [N][$];
  int         slens  [N][$];
  int         spos   [N];
  bit         src_en = 1'b1;
  int         ready_mode = 0, stall_prob = 0;
  int         stall_src = -1, stall_after = 0, stall_left = 0;

  // Reference model.
  int         m_phase, m_ptr, m_owner, m_gap, m_beats;
  logic [N-1:0] e_ready;
  logic       e_valid, e_last, e_abort;
  logic [W-1:0] e_data;

  // Observations of the DUT net side.
  int d_order[$], d_len[$], d_first[$], d_lastc[$];
  int d_cur = 0, d_beats = 0, d_aborts = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic clear_logs();
    d_order.delete(); d_len.delete(); d_first.delete(); d_lastc.delete();
    d_cur = 0; d_beats = 0; d_aborts = 0;
  endtask

  task automatic pad_logs(input int n);
    while (d_order.size() < n) d_order.push_back(-1);
    while (d_len.size()   < n) d_len.push_back(-1);
    while (d_first.size() < n) d_first.push_back(-1);
    while (d_lastc.size() < n) d_lastc.push_back(-1);
  endtask

  task automatic push_frame(input int s, input int len);
    for (int b = 0; b < len; b++) sbytes[s].push_back(8'($urandom));
    slens[s].push_back(len);
  endtask

  task automatic model_reset();
    m_phase = PIdle; m_ptr = 0; m_owner = 0; m_gap = 0; m_beats = 0;
  endtask

  task automatic model_outputs();
    e_ready = '0; e_valid = 1'b0; e_last = 1'b0; e_abort = 1'b0; e_data = '0;
    if (m_phase == PXfer) begin
      e_valid          = src_tvalid[m_owner];
      e_data           = src_tdata[m_owner*W +: W];
      e_last           = src_tlast[m_owner] || (Wd && m_beats == MaxBeats - 1);
      e_ready[m_owner] = net_tready;
      e_abort          = Wd && e_valid && net_tready && !src_tlast[m_owner]
                         && m_beats == MaxBeats - 1;
    end else if (m_phase == PDrain) begin
      e_ready[m_owner] = 1'b1;
    end
  endtask

  task automatic model_finish();
    m_ptr = (m_owner + 1) % N;
    if (IFG > 0) begin m_phase = PGap; m_gap = IFG; end
    else m_phase = PIdle;
  endtask

  // Advance the model across one clock edge using the inputs held during the cycle.
  task automatic model_step();
    bit found;
    for (int i = 0; i < N; i++) begin
      if (src_tvalid[i] && e_ready[i]) begin
        void'(sbytes[i].pop_front());
        spos[i]++;
        if (spos[i] == slens[i][0]) begin
          void'(slens[i].pop_front());
          spos[i] = 0;
        end
      end
    end
    case (m_phase)
      PIdle: begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && src_tvalid[(m_ptr + k) % N]) begin
            found = 1'b1; m_owner = (m_ptr + k) % N; m_phase = PXfer; m_beats = 0;
          end
        end
      end
      PXfer: begin
        if (e_valid && net_tready) begin
          if (src_tlast[m_owner]) model_finish();
          else if (e_abort) m_phase = PDrain;
          else m_beats++;
        end
      end
      PGap: begin
        m_gap--;
        if (m_gap == 0) m_phase = PIdle;
      end
      default: begin
        if (src_tvalid[m_owner] && src_tlast[m_owner]) model_finish();
      end
    endcase
  endtask

  task automatic drive_inputs();
    bit v;
    case (ready_mode)
      0:       net_tready = 1'b1;
      1:       net_tready = ~net_tready;
      default: net_tready = ($urandom_range(0, 99) < 70);
    endcase
    for (int i = 0; i < N; i++) begin
      if (src_en && slens[i].size() > 0) begin
        v = 1'b1;
        if (stall_prob > 0 && $urandom_range(0, 99) < stall_prob) v = 1'b0;
        if (i == stall_src && spos[i] == stall_after && stall_left > 0) begin
          v = 1'b0; stall_left--;
        end
        src_tvalid[i]          = v;
        src_tdata[i*W +: W]    = sbytes[i][0];
        src_tlast[i]           = (spos[i] == slens[i][0] - 1);
      end else begin
        src_tvalid[i]       = 1'b0;
        src_tdata[i*W +: W] = '0;
        src_tlast[i]        = 1'b0;
      end
    end
  endtask

  task automatic compare();
    chk("grant_active", grant_active, m_phase == PXfer);
    chk("grant_id", grant_id, m_owner);
    chk("src_tready", src_tready, e_ready);
    chk("net_tvalid", net_tvalid, e_valid);
    chk("net_tlast", net_tlast, e_last);
    chk("net_tdata", net_tdata, e_data);
    chk("frame_abort", frame_abort, e_abort);
    if (frame_abort) d_aborts++;
    if (net_tvalid && net_tready) begin
      if (d_cur == 0) d_first.push_back(cyc);
      d_cur++; d_beats++;
      if (net_tlast) begin
        d_order.push_back(grant_id); d_len.push_back(d_cur); d_lastc.push_back(cyc);
        d_cur = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    if (rstn) model_step();
    #1;
    drive_inputs();
    #1;
    model_outputs();
    if (rstn) compare();
  endtask

  function automatic bit busy();
    busy = (m_phase != PIdle);
    for (int i = 0; i < N; i++) if (slens[i].size() > 0) busy = 1'b1;
  endfunction

  task automatic run_quiet(input string name, input int budget);
    int n = 0;
    while (busy() && n < budget) begin cycle(); n++; end
    checks++;
    if (n >= budget) begin
      fails++;
      $display("FAIL %s timeout after %0d cycles", name, n);
    end
    repeat (3) cycle();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_active"}, grant_active, 0);
    chk({tag, "_gid"}, grant_id, 0);
    chk({tag, "_ready"}, src_tready, 0);
    chk({tag, "_valid"}, net_tvalid, 0);
    chk({tag, "_last"}, net_tlast, 0);
    chk({tag, "_data"}, net_tdata, 0);
    chk({tag, "_abort"}, frame_abort, 0);
  endtask

  initial begin
    int n, rem;
    rstn = 1'b0; src_tvalid = '0; src_tdata = '0; src_tlast = '0; net_tready = 1'b0;
    for (int i = 0; i < N; i++) spos[i] = 0;
    model_reset();
    #3;
    chk_reset_outputs("reset");
    repeat (2) cycle();
    rstn = 1'b1;

    // A: long frame from src0 while src1 waits through the gap.
    clear_logs();
    push_frame(0, ALen); push_frame(1, 5);
    run_quiet("A", 2000);
    chk("A_frames", d_order.size(), 2);
    pad_logs(2);
    chk("A_first_src", d_order[0], 0);
    chk("A_len", d_len[0], ALen);
    chk("A_second_src", d_order[1], 1);
    chk("A_gap_to_next_beat", d_first[1] - d_lastc[0], 14);

    // B: both sources saturated.
    clear_logs();
    for (int f = 0; f < 3; f++) begin push_frame(0, 10); push_frame(1, 10); end
    run_quiet("B", 2000);
    chk("B_frames", d_order.size(), 6);
    pad_logs(6);
    for (int f = 0; f < 6; f++) begin
      chk("B_order", d_order[f], f % 2);
      chk("B_len", d_len[f], 10);
    end

    // C: toggling downstream ready.
    clear_logs();
    ready_mode = 1;
    push_frame(1, 20);
    run_quiet("C", 2000);
    ready_mode = 0;
    chk("C_frames", d_order.size(), 1);
    pad_logs(1);
    chk("C_src", d_order[0], 1);
    chk("C_beats", d_beats, 20);

    // D: src0 stalls mid-frame for 5 cycles; grant must hold.
    clear_logs();
    stall_src = 0; stall_after = 4; stall_left = 5;
    push_frame(0, 10); push_frame(1, 10);
    run_quiet("D", 2000);
    stall_src = -1;
    chk("D_frames", d_order.size(), 2);
    pad_logs(2);
    chk("D_first_src", d_order[0], 0);
    chk("D_stall_span", d_lastc[0] - d_first[0], 14);
    chk("D_second_src", d_order[1], 1);
    chk("D_gap_to_next_beat", d_first[1] - d_lastc[0], 14);

    // E: reset at byte 7 of a frame, after the pointer has moved to 1.
    clear_logs();
    push_frame(0, 5);
    run_quiet("E_pre", 500);
    push_frame(0, 12);
    n = 0;
    while (!(m_phase == PXfer && m_beats == 6) && n < 500) begin cycle(); n++; end
    checks++;
    if (n >= 500) begin fails++; $display("FAIL E_wait timeout after %0d cycles", n); end
    rstn = 1'b0;
    #1;
    chk_reset_outputs("E_midframe");
    model_reset();
    rem = slens[0][0] - spos[0];
    for (int b = 0; b < rem; b++) void'(sbytes[0].pop_front());
    void'(slens[0].pop_front());
    spos[0] = 0;
    repeat (2) cycle();
    rstn = 1'b1;
    clear_logs();
    push_frame(1, 3); push_frame(0, 3);
    run_quiet("E_post", 500);
    chk("E_frames", d_order.size(), 2);
    pad_logs(2);
    chk("E_first_src", d_order[0], 0);
    chk("E_second_src", d_order[1], 1);

`ifdef NET_ARB_WATCHDOG_EN
    // F: oversized frame is cut at MaxBeats and the remainder drained.
    clear_logs();
    push_frame(0, 40); push_frame(1, 5);
    run_quiet("F", 2000);
    chk("F_frames", d_order.size(), 2);
    pad_logs(2);
    chk("F_first_src", d_order[0], 0);
    chk("F_cut_len", d_len[0], 16);
    chk("F_aborts", d_aborts, 1);
    chk("F_second_src", d_order[1], 1);
    chk("F_second_len", d_len[1], 5);
    chk("F_drain_and_gap", d_first[1] - d_lastc[0], 38);
`endif

    // G: random traffic, stalls and backpressure.
    clear_logs();
    ready_mode = 2; stall_prob = 20;
    for (int f = 0; f < 60; f++) push_frame($urandom_range(0, N - 1), $urandom_range(1, 24));
    run_quiet("G", 20000);
    chk("G_frames", d_order.size(), 60);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
